// File: rtl/mdio_arbiter.sv
// rtl/mdio_arbiter.sv - round-robin arbiter sharing one MDIO master among N_REQ requesters
module mdio_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*N_REQ-1:0]    req_phy_addr,
  input  logic [5*N_REQ-1:0]    req_reg_addr,
  input  logic [16*N_REQ-1:0]   req_data,
  input  logic [2*N_REQ-1:0]    req_opcode,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  output logic [15:0]           rsp_data,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [4:0]            m_cmd_phy_addr,
  output logic [4:0]            m_cmd_reg_addr,
  output logic [15:0]           m_cmd_data,
  output logic [1:0]            m_cmd_opcode,
  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  input  logic [15:0]           m_data_out,
  input  logic                  m_data_out_valid,
  output logic                  m_data_out_ready,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RETURN} state_t;
  state_t state;

  logic [ID_W-1:0] last;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] cand;
  logic            found;
  int              idx;
  logic [4:0]      sel_phy;
  logic [4:0]      sel_reg;
  logic [15:0]     sel_data;
  logic [1:0]      sel_op;

  // Search starts just past the last grant and wraps, giving round-robin fairness.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx  = (int'(last) + k) % N_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    sel_phy  = '0;
    sel_reg  = '0;
    sel_data = '0;
    sel_op   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        sel_phy  = req_phy_addr[5*i +: 5];
        sel_reg  = req_reg_addr[5*i +: 5];
        sel_data = req_data[16*i +: 16];
        sel_op   = req_opcode[2*i +: 2];
      end
    end
  end

  assign req_ready = (state == IDLE && found) ? (N_REQ'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      m_cmd_valid      <= 1'b0;
      busy             <= 1'b0;
      rsp_valid        <= '0;
      rsp_data         <= '0;
      m_data_out_ready <= 1'b1;
      grant_id         <= '0;
      last             <= ID_W'(N_REQ - 1);
      m_cmd_phy_addr   <= '0;
      m_cmd_reg_addr   <= '0;
      m_cmd_data       <= '0;
      m_cmd_opcode     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            m_cmd_phy_addr   <= sel_phy;
            m_cmd_reg_addr   <= sel_reg;
            m_cmd_data       <= sel_data;
            m_cmd_opcode     <= sel_op;
            grant_id         <= sel;
            last             <= sel;
            m_cmd_valid      <= 1'b1;
            busy             <= 1'b1;
            m_data_out_ready <= 1'b0;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_cmd_ready) begin
            m_cmd_valid      <= 1'b0;
            m_data_out_ready <= 1'b1;
            // Opcode 00 and 01 both complete without a response.
            if (m_cmd_opcode[1]) begin
              state <= WAIT_RSP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        WAIT_RSP: begin
          if (m_data_out_valid) begin
            rsp_data         <= m_data_out;
            rsp_valid        <= N_REQ'(1) << grant_id;
            m_data_out_ready <= 1'b0;
            state            <= RETURN;
          end
        end
        RETURN: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid        <= '0;
            busy             <= 1'b0;
            m_data_out_ready <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// tb/tb_mdio_arbiter.sv - randomized self-checking bench for mdio_arbiter
module tb_mdio_arbiter;
  localparam int N = 4;
  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [5*N-1:0]  req_phy_addr = '0;
  logic [5*N-1:0]  req_reg_addr = '0;
  logic [16*N-1:0] req_data = '0;
  logic [2*N-1:0]  req_opcode = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [15:0]     rsp_data;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [4:0]      m_cmd_phy_addr;
  logic [4:0]      m_cmd_reg_addr;
  logic [15:0]     m_cmd_data;
  logic [1:0]      m_cmd_opcode;
  logic            m_cmd_valid;
  logic            m_cmd_ready = 1'b0;
  logic [15:0]     m_data_out = '0;
  logic            m_data_out_valid = 1'b0;
  logic            m_data_out_ready;
  logic [ID_W-1:0] grant_id;
  logic            busy;

  mdio_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_phy_addr(req_phy_addr), .req_reg_addr(req_reg_addr), .req_data(req_data),
    .req_opcode(req_opcode), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .m_cmd_phy_addr(m_cmd_phy_addr), .m_cmd_reg_addr(m_cmd_reg_addr),
    .m_cmd_data(m_cmd_data), .m_cmd_opcode(m_cmd_opcode),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid),
    .m_data_out_ready(m_data_out_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int last_g = N - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: lowest valid index above the last grant, else lowest overall.
  function automatic int exp_sel(input logic [N-1:0] v, input int last);
    for (int i = last + 1; i < N; i++) if (v[i]) return i;
    for (int i = 0; i <= last; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_g = N - 1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_cmd_valid", 32'(m_cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dout_ready", 32'(m_data_out_ready), 1);
    chk("rst_grant_id", 32'(grant_id), 0);
  endtask

  task automatic set_req(input int i, input logic [4:0] phy, input logic [4:0] rg,
                         input logic [15:0] d, input logic [1:0] op);
    req_phy_addr[5*i +: 5] = phy;
    req_reg_addr[5*i +: 5] = rg;
    req_data[16*i +: 16]   = d;
    req_opcode[2*i +: 2]   = op;
  endtask

  // One full transaction from IDLE; caller has already driven the request inputs.
  task automatic run_txn(input logic [15:0] rdata, input int bp);
    int s;
    int d;
    logic [4:0]  phy, rg;
    logic [15:0] dat;
    logic [1:0]  op;
    logic [N-1:0] oh;
    #1;
    s = exp_sel(req_valid, last_g);
    if (s < 0) begin
      chk("idle_req_ready", 32'(req_ready), 0);
      m_data_out = rdata;
      m_data_out_valid = 1'b1;
      chk("drain_ready", 32'(m_data_out_ready), 1);
      step();
      m_data_out_valid = 1'b0;
      chk("drain_no_rsp", 32'(rsp_valid), 0);
      chk("drain_busy", 32'(busy), 0);
      return;
    end
    oh = N'(1) << s;
    chk("req_ready", 32'(req_ready), 32'(oh));
    phy = req_phy_addr[5*s +: 5];
    rg  = req_reg_addr[5*s +: 5];
    dat = req_data[16*s +: 16];
    op  = req_opcode[2*s +: 2];
    last_g = s;
    step();
    chk("cmd_fields", {m_cmd_valid, m_cmd_phy_addr, m_cmd_reg_addr, m_cmd_data, m_cmd_opcode},
        {3'b0, 1'b1, phy, rg, dat, op});
    chk("grant_id", 32'(grant_id), s);
    chk("issue_busy", 32'(busy), 1);
    chk("issue_req_ready", 32'(req_ready), 0);
    chk("issue_dout_ready", 32'(m_data_out_ready), 0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      step();
      chk("cmd_hold", {m_cmd_valid, m_cmd_phy_addr, m_cmd_reg_addr, m_cmd_data, m_cmd_opcode},
          {3'b0, 1'b1, phy, rg, dat, op});
    end
    m_cmd_ready = 1'b1;
    step();
    m_cmd_ready = 1'b0;
    if (!op[1]) begin
      chk("wr_done", {busy, m_cmd_valid, m_data_out_ready}, 3'b001);
      chk("wr_no_rsp", 32'(rsp_valid), 0);
      return;
    end
    chk("wait_state", {busy, m_cmd_valid, m_data_out_ready}, 3'b101);
    chk("wait_no_rsp", 32'(rsp_valid), 0);
    d = $urandom_range(0, 3);
    repeat (d) step();
    m_data_out = rdata;
    m_data_out_valid = 1'b1;
    step();
    m_data_out_valid = 1'b0;
    m_data_out = 16'($urandom);
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_data", 32'(rsp_data), 32'(rdata));
    chk("ret_dout_ready", 32'(m_data_out_ready), 0);
    repeat (bp) begin
      rsp_ready = N'($urandom) & ~oh;
      req_valid = N'($urandom);
      step();
      chk("rsp_hold", {rsp_valid, rsp_data}, {oh, rdata});
      chk("ret_no_grant", {req_ready, m_data_out_ready, m_cmd_valid}, 0);
    end
    rsp_ready = oh | N'($urandom);
    step();
    rsp_ready = '0;
    chk("ret_done", {rsp_valid, busy, m_data_out_ready}, 32'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Directed write from requester 0
    set_req(0, 5'd3, 5'h00, 16'h1140, 2'b01);
    req_valid = 4'b0001;
    run_txn(16'h0, 0);
    req_valid = '0;

    // Directed read from requester 2 with a long response stall
    set_req(2, 5'd1, 5'h01, 16'h0000, 2'b10);
    req_valid = 4'b0100;
    run_txn(16'h796D, 20);
    req_valid = '0;

    // Stray master data in IDLE
    run_txn(16'hBEEF, 0);

    // All requesters valid: strict rotation from a fresh reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i), 5'(i), 16'(i), 2'b01);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_txn(16'h0, 0);
      chk("rr_order", 32'(grant_id), i % N);
    end

    // Reset during WAIT_RSP aborts without a response
    req_valid = '0;
    set_req(1, 5'd7, 5'h02, 16'h0, 2'b11);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    m_cmd_ready = 1'b1;
    step();
    m_cmd_ready = 1'b0;
    chk("pre_rst_wait", {busy, m_data_out_ready}, 2'b11);
    do_reset();
    m_data_out = 16'h1234;
    m_data_out_valid = 1'b1;
    step();
    m_data_out_valid = 1'b0;
    chk("post_rst_no_rsp", 32'(rsp_valid), 0);
    req_valid = 4'b1111;
    run_txn(16'h0, 0);
    chk("post_rst_first", 32'(grant_id), 0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 5'($urandom), 5'($urandom), 16'($urandom), 2'($urandom));
      req_valid = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      run_txn(16'($urandom), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
